uart_rx_oversampled: RTL and testbench

//  - Receives one 8N1/8E1/8O1 UART serial frame per character on RXD using 16x oversampling.
//  - Produces a parallel byte, a one-cycle valid strobe and per-frame parity/stop error flags.
//  - Receive end of the link; the matching transmitter drives TXD with LSB-first frames.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_rx_oversampled.sv | 150 +++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit ends of the link.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  // Result of one received character, registered as a unit when the stop bit is decided.
  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 perr;
    logic                 serr;
  } rx_result_t;

  // Clocks per oversample tick (integer division, truncating).
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clocks; clr restarts the phase.
// Latency: tick is combinational from the counter; no backpressure.
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1/8E1/8O1 UART receiver, 16x oversampled with 2-of-3 majority per bit.
// Latency: Valid_rx 1 clk after the stop-bit decision; no backpressure (Valid_rx is a pulse).
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 Valid_rx,
  output logic                 Parity_error,
  output logic                 Stop_error,
  output logic                 rx_busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);

  logic [1:0]           sync_q;
  logic                 rxs, rxs_prev_q;
  uart_state_e          state_q, state_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [2:0]           bidx_q, bidx_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 pbit_q, pbit_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  rx_result_t           res_q, res_d;
  logic                 tick, tick_clr, maj, at_dec, at_wrap;

  assign rxs = sync_q[1];

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bidx_d   = bidx_q;
    smp_d    = smp_q;
    shreg_d  = shreg_q;
    pbit_d   = pbit_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    res_d    = res_q;
    tick_clr = 1'b0;

    // The third vote is the live sample taken at the decision point itself.
    maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
    at_dec  = tick && (scnt_q == SW'(M + 1));
    at_wrap = tick && (scnt_q == SW'(OVERSAMPLE - 1));

    if (state_q != ST_IDLE && tick) begin
      scnt_d = at_wrap ? '0 : scnt_q + SW'(1);
      if (scnt_q == SW'(M - 1) || scnt_q == SW'(M)) smp_d = {smp_q[0], rxs};
    end

    case (state_q)
      ST_IDLE: begin
        if (rxs_prev_q && !rxs) begin
          state_d  = ST_START;
          scnt_d   = '0;
          tick_clr = 1'b1;
        end
      end
      ST_START: begin
        if (at_dec) begin
          if (maj) state_d = ST_IDLE;
          else     busy_d  = 1'b1;
        end else if (at_wrap) begin
          state_d = ST_DATA;
          bidx_d  = '0;
        end
      end
      ST_DATA: begin
        if (at_dec) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (at_wrap) begin
          bidx_d = bidx_q + 3'd1;
          if (bidx_q == 3'd7) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (at_dec)  pbit_d  = maj;
        if (at_wrap) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Leave half a bit early so the next start edge is never missed under baud skew.
        if (at_dec) begin
          valid_d    = 1'b1;
          busy_d     = 1'b0;
          res_d.data = shreg_q;
          res_d.serr = ~maj;
          res_d.perr = (PARITY_EN != 0) ? ((^{shreg_q, pbit_q}) != (PARITY_ODD != 0)) : 1'b0;
          state_d    = maj ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= 2'b11;
      rxs_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      scnt_q     <= '0;
      bidx_q     <= '0;
      smp_q      <= 2'b11;
      shreg_q    <= '0;
      pbit_q     <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      res_q      <= '0;
    end else begin
      sync_q     <= {sync_q[0], RXD};
      rxs_prev_q <= rxs;
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      bidx_q     <= bidx_d;
      smp_q      <= smp_d;
      shreg_q    <= shreg_d;
      pbit_q     <= pbit_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      res_q      <= res_d;
    end
  end

  assign RX_Data      = res_q.data;
  assign Parity_error = res_q.perr;
  assign Stop_error   = res_q.serr;
  assign Valid_rx     = valid_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled at DIV = 1 (16 clk per bit, 100 ns clock).
`timescale 1ns/1ns
module tb_uart_rx_oversampled;

  localparam int BIT_NS  = 1600;
  localparam int SKEW_NS = 1569;  // transmitter 2% fast

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       RXD   = 1'b1;
  logic [7:0] RX_Data;
  logic       Valid_rx, Parity_error, Stop_error, rx_busy;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         vcnt    = 0;
  int         errcnt  = 0;
  logic [7:0] cap_q[$];
  logic       last_perr = 1'b0;
  logic       last_serr = 1'b0;

  uart_rx_oversampled #(
    .CLK_FREQ   (1_600_000),
    .BAUD_RATE  (100_000),
    .OVERSAMPLE (16),
    .PARITY_EN  (1),
    .PARITY_ODD (0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RXD          (RXD),
    .RX_Data      (RX_Data),
    .Valid_rx     (Valid_rx),
    .Parity_error (Parity_error),
    .Stop_error   (Stop_error),
    .rx_busy      (rx_busy)
  );

  always #50 clk = ~clk;

  always @(negedge clk) begin
    if (Valid_rx) begin
      vcnt++;
      cap_q.push_back(RX_Data);
      last_perr = Parity_error;
      last_serr = Stop_error;
      if (Parity_error || Stop_error) errcnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb, input int bt);
    RXD = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      RXD = d[i];
      #(bt);
    end
    RXD = pb;
    #(bt);
    RXD = sb;
    #(bt);
  endtask

  task automatic line_idle(input int nbits);
    RXD = 1'b1;
    #(nbits * BIT_NS);
  endtask

  task automatic test_reset;
    #230;
    n_tests++; if (RX_Data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", RX_Data); end
    n_tests++; if (Valid_rx !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", Valid_rx); end
    n_tests++; if (Parity_error !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", Parity_error); end
    n_tests++; if (Stop_error !== 1'b0) begin n_fail++; $display("FAIL reset_serr: got %b want 0", Stop_error); end
    n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    @(negedge clk);
    reset = 1'b1;
    #17;
    line_idle(2);
  endtask

  task automatic test_basic;
    int   v0;
    logic busy_mid;
    v0       = vcnt;
    busy_mid = 1'b0;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, BIT_NS);
      begin #(BIT_NS * 5); busy_mid = rx_busy; end
    join
    line_idle(2);
    n_tests++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL t1_pulses: got %0d want 1", vcnt - v0); end
    n_tests++; if (cap_q[cap_q.size()-1] !== 8'hA5) begin n_fail++; $display("FAIL t1_data: got %h want a5", cap_q[cap_q.size()-1]); end
    n_tests++; if (last_perr !== 1'b0 || last_serr !== 1'b0) begin n_fail++; $display("FAIL t1_err: got p=%b s=%b want 0 0", last_perr, last_serr); end
    n_tests++; if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL t1_busy_mid: got %b want 1", busy_mid); end
    n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_end: got %b want 0", rx_busy); end
  endtask

  task automatic test_parity;
    int v0;
    v0 = vcnt;
    send_frame(8'h3C, 1'b1, 1'b1, BIT_NS);
    line_idle(2);
    n_tests++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL t2_pulses: got %0d want 1", vcnt - v0); end
    n_tests++; if (RX_Data !== 8'h3C) begin n_fail++; $display("FAIL t2_data: got %h want 3c", RX_Data); end
    n_tests++; if (Parity_error !== 1'b1) begin n_fail++; $display("FAIL t2_perr_bad: got %b want 1", Parity_error); end
    n_tests++; if (Stop_error !== 1'b0) begin n_fail++; $display("FAIL t2_serr: got %b want 0", Stop_error); end
    send_frame(8'h3C, 1'b0, 1'b1, BIT_NS);
    line_idle(2);
    n_tests++; if (vcnt - v0 !== 2) begin n_fail++; $display("FAIL t2_pulses2: got %0d want 2", vcnt - v0); end
    n_tests++; if (Parity_error !== 1'b0) begin n_fail++; $display("FAIL t2_perr_good: got %b want 0", Parity_error); end
  endtask

  task automatic test_break;
    int v0;
    v0 = vcnt;
    send_frame(8'h00, 1'b0, 1'b0, BIT_NS);
    #(40 * BIT_NS);
    n_tests++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL t3_pulses: got %0d want 1", vcnt - v0); end
    n_tests++; if (last_serr !== 1'b1) begin n_fail++; $display("FAIL t3_serr: got %b want 1", last_serr); end
    n_tests++; if (Stop_error !== 1'b1) begin n_fail++; $display("FAIL t3_serr_hold: got %b want 1", Stop_error); end
    n_tests++; if (RX_Data !== 8'h00 || Parity_error !== 1'b0) begin n_fail++; $display("FAIL t3_data: got %h p=%b want 00 p=0", RX_Data, Parity_error); end
    n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL t3_busy: got %b want 0", rx_busy); end
    line_idle(2);
    send_frame(8'h55, 1'b0, 1'b1, BIT_NS);
    line_idle(2);
    n_tests++; if (vcnt - v0 !== 2) begin n_fail++; $display("FAIL t3_after_pulses: got %0d want 2", vcnt - v0); end
    n_tests++; if (RX_Data !== 8'h55 || Stop_error !== 1'b0) begin n_fail++; $display("FAIL t3_after: got %h s=%b want 55 s=0", RX_Data, Stop_error); end
  endtask

  task automatic test_glitch;
    int   v0;
    logic busy_seen;
    v0        = vcnt;
    busy_seen = 1'b0;
    fork
      begin RXD = 1'b0; #400; RXD = 1'b1; end
      repeat (60) begin @(negedge clk); if (rx_busy) busy_seen = 1'b1; end
    join
    n_tests++; if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL t4_pulses: got %0d want 0", vcnt - v0); end
    n_tests++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL t4_busy: got %b want 0", busy_seen); end
    send_frame(8'hC3, 1'b0, 1'b1, BIT_NS);
    line_idle(2);
    n_tests++; if (vcnt - v0 !== 1 || RX_Data !== 8'hC3) begin n_fail++; $display("FAIL t4_recover: got n=%0d %h want n=1 c3", vcnt - v0, RX_Data); end
  endtask

  task automatic test_back_to_back;
    int v0, e0, base;
    v0   = vcnt;
    e0   = errcnt;
    base = cap_q.size();
    send_frame(8'h00, 1'b0, 1'b1, SKEW_NS);
    send_frame(8'hFF, 1'b0, 1'b1, SKEW_NS);
    send_frame(8'h81, 1'b0, 1'b1, SKEW_NS);
    line_idle(2);
    n_tests++; if (vcnt - v0 !== 3) begin n_fail++; $display("FAIL t5_pulses: got %0d want 3", vcnt - v0); end
    n_tests++; if (cap_q[base] !== 8'h00) begin n_fail++; $display("FAIL t5_byte0: got %h want 00", cap_q[base]); end
    n_tests++; if (cap_q[base+1] !== 8'hFF) begin n_fail++; $display("FAIL t5_byte1: got %h want ff", cap_q[base+1]); end
    n_tests++; if (cap_q[base+2] !== 8'h81) begin n_fail++; $display("FAIL t5_byte2: got %h want 81", cap_q[base+2]); end
    n_tests++; if (errcnt - e0 !== 0) begin n_fail++; $display("FAIL t5_errors: got %0d want 0", errcnt - e0); end
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    v0 = vcnt;
    fork
      send_frame(8'hF0, 1'b0, 1'b1, BIT_NS);
      begin
        #(BIT_NS * 4 + 300);
        reset = 1'b0;
        #10;
        n_tests++; if (RX_Data !== 8'h00) begin n_fail++; $display("FAIL t6_data: got %h want 00", RX_Data); end
        n_tests++; if (rx_busy !== 1'b0 || Valid_rx !== 1'b0) begin n_fail++; $display("FAIL t6_busy_valid: got %b %b want 0 0", rx_busy, Valid_rx); end
        n_tests++; if (Parity_error !== 1'b0 || Stop_error !== 1'b0) begin n_fail++; $display("FAIL t6_flags: got %b %b want 0 0", Parity_error, Stop_error); end
      end
    join
    line_idle(1);
    @(negedge clk);
    reset = 1'b1;
    #17;
    line_idle(2);
    send_frame(8'h0F, 1'b0, 1'b1, BIT_NS);
    line_idle(2);
    n_tests++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL t6_pulses: got %0d want 1", vcnt - v0); end
    n_tests++; if (RX_Data !== 8'h0F || Parity_error !== 1'b0) begin n_fail++; $display("FAIL t6_after: got %h p=%b want 0f p=0", RX_Data, Parity_error); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
